// File: rtl/pipelined_bypass_adder.sv
// Pipelined carry-skip adder/subtractor with valid/ready handshake.
// N bits are split into STAGES segments; the carry between segments is registered.
module pipelined_bypass_adder #(
  parameter int N      = 32,
  parameter int K      = 4,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin,
  input  logic         Sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] Sum,
  output logic         Cout,
  output logic         Overflow
);

  localparam int NUM_BLOCKS = N / K;
  localparam int SEG        = N / STAGES;
  localparam int BPS        = NUM_BLOCKS / STAGES;
  localparam int L          = STAGES - 1;

  if (K < 1 || STAGES < 1 || (N % K) != 0 || (NUM_BLOCKS % STAGES) != 0) begin : g_bad_params
    $error("pipelined_bypass_adder: N must be a multiple of K and N/K a multiple of STAGES");
  end

  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  for (genvar s = 0; s < STAGES; s++) begin : g_seg
    localparam int LO = s * SEG;
    localparam int W  = N - LO;
    localparam logic [N-1:0] MASK = N'({SEG{1'b1}}) << LO;

    // a_q carries finished sum bits below LO and untouched operand A bits above;
    // b_q holds only the not-yet-consumed operand B bits, right-aligned.
    logic [N-1:0]   a_q, a_nx;
    logic [W-1:0]   b_q;
    logic           c_q, v_q, c_nx;
    logic [SEG-1:0] p, g, ci, seg_sum;

    if (s == 0) begin : g_load
      always_ff @(posedge clk) begin
        if (rst) begin
          v_q <= 1'b0;
          a_q <= '0;
          b_q <= '0;
          c_q <= 1'b0;
        end else if (adv) begin
          v_q <= in_valid;
          if (in_valid) begin
            a_q <= A;
            b_q <= Sub ? ~B : B;
            c_q <= Sub ? 1'b1 : Cin;
          end
        end
      end
    end else begin : g_shift
      always_ff @(posedge clk) begin
        if (rst) begin
          v_q <= 1'b0;
          a_q <= '0;
          b_q <= '0;
          c_q <= 1'b0;
        end else if (adv) begin
          v_q <= g_seg[s-1].v_q;
          a_q <= g_seg[s-1].a_nx;
          b_q <= g_seg[s-1].b_q[W+SEG-1:SEG];
          c_q <= g_seg[s-1].c_nx;
        end
      end
    end

    assign p = a_q[LO +: SEG] ^ b_q[SEG-1:0];
    assign g = a_q[LO +: SEG] & b_q[SEG-1:0];

    // ci[i] is the carry into bit i; each block's carry-out goes through the skip mux
    always_comb begin
      logic c, rc;
      ci   = '0;
      c    = c_q;
      rc   = 1'b0;
      c_nx = 1'b0;
      for (int j = 0; j < BPS; j++) begin
        rc = c;
        for (int i = 0; i < K; i++) begin
          ci[j*K+i] = rc;
          rc        = g[j*K+i] | (p[j*K+i] & rc);
        end
        c = (&p[j*K +: K]) ? c : rc;
      end
      c_nx = c;
    end

    assign seg_sum = p ^ ci;
    assign a_nx    = (a_q & ~MASK) | (N'(seg_sum) << LO);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      Sum       <= '0;
      Cout      <= 1'b0;
      Overflow  <= 1'b0;
    end else if (adv) begin
      out_valid <= g_seg[L].v_q;
      Overflow  <= g_seg[L].v_q & (g_seg[L].ci[SEG-1] ^ g_seg[L].c_nx);
      if (g_seg[L].v_q) begin
        Sum  <= g_seg[L].a_nx;
        Cout <= g_seg[L].c_nx;
      end
    end
  end

endmodule

// File: tb/tb_pipelined_bypass_adder.sv
// Directed bench for pipelined_bypass_adder: default config plus N=16/STAGES=4 and N=64/STAGES=1.
// Covers latency, skip path, subtract/overflow, backpressure ordering and mid-stream reset.
module tb_pipelined_bypass_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic Cin = 1'b0;
  logic Sub = 1'b0;
  logic out_ready = 1'b1;

  logic [31:0] a32 = '0, b32 = '0, sum32;
  logic [15:0] a16 = '0, b16 = '0, sum16;
  logic [63:0] a64 = '0, b64 = '0, sum64;
  logic ir32, ir16, ir64, ov32, ov16, ov64;
  logic co32, co16, co64, of32, of16, of64;

  always #5 clk = ~clk;

  pipelined_bypass_adder dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir32), .A(a32), .B(b32),
    .Cin(Cin), .Sub(Sub), .out_valid(ov32), .out_ready(out_ready), .Sum(sum32),
    .Cout(co32), .Overflow(of32));

  pipelined_bypass_adder #(.N(16), .K(2), .STAGES(4)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir16), .A(a16), .B(b16),
    .Cin(Cin), .Sub(Sub), .out_valid(ov16), .out_ready(out_ready), .Sum(sum16),
    .Cout(co16), .Overflow(of16));

  pipelined_bypass_adder #(.N(64), .K(8), .STAGES(1)) dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir64), .A(a64), .B(b64),
    .Cin(Cin), .Sub(Sub), .out_valid(ov64), .out_ready(out_ready), .Sum(sum64),
    .Cout(co64), .Overflow(of64));

  int n_tests = 0;
  int n_fail  = 0;

  int lat32, lat16, lat64;
  logic [31:0] r_sum32;
  logic [15:0] r_sum16;
  logic [63:0] r_sum64;
  logic r_co32, r_co16, r_co64, r_of32, r_of16, r_of64;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: {overflow, carry-out, sum} from plain wide arithmetic and the sign rule.
  function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic cin, input logic sub);
    logic [31:0] be;
    logic        c0;
    logic [32:0] t;
    logic        ovf;
    be  = sub ? ~b : b;
    c0  = sub ? 1'b1 : cin;
    t   = {1'b0, a} + {1'b0, be} + 33'(c0);
    ovf = (a[31] == be[31]) && (t[31] != a[31]);
    return {ovf, t[32], t[31:0]};
  endfunction

  // Called just after a clock edge with all pipelines empty and out_ready=1.
  task automatic apply(input logic [31:0] x32, input logic [31:0] y32,
                       input logic [15:0] x16, input logic [15:0] y16,
                       input logic [63:0] x64, input logic [63:0] y64,
                       input logic cin, input logic sub);
    a32 = x32; b32 = y32; a16 = x16; b16 = y16; a64 = x64; b64 = y64;
    Cin = cin; Sub = sub; in_valid = 1'b1;
    lat32 = -1; lat16 = -1; lat64 = -1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      if (ov32 && lat32 < 0) begin lat32 = k; r_sum32 = sum32; r_co32 = co32; r_of32 = of32; end
      if (ov16 && lat16 < 0) begin lat16 = k; r_sum16 = sum16; r_co16 = co16; r_of16 = of16; end
      if (ov64 && lat64 < 0) begin lat64 = k; r_sum64 = sum64; r_co64 = co64; r_of64 = of64; end
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] s, input logic co, input logic of);
    check({tag, ".lat32"}, 64'(lat32), 64'd2);
    check({tag, ".sum32"}, 64'(r_sum32), 64'(s));
    check({tag, ".cout32"}, 64'(r_co32), 64'(co));
    check({tag, ".ovf32"}, 64'(r_of32), 64'(of));
  endtask

  task automatic chk16(input string tag, input logic [15:0] s, input logic co, input logic of);
    check({tag, ".lat16"}, 64'(lat16), 64'd4);
    check({tag, ".sum16"}, 64'(r_sum16), 64'(s));
    check({tag, ".cout16"}, 64'(r_co16), 64'(co));
    check({tag, ".ovf16"}, 64'(r_of16), 64'(of));
  endtask

  task automatic chk64(input string tag, input logic [63:0] s, input logic co, input logic of);
    check({tag, ".lat64"}, 64'(lat64), 64'd1);
    check({tag, ".sum64"}, r_sum64, s);
    check({tag, ".cout64"}, 64'(r_co64), 64'(co));
    check({tag, ".ovf64"}, 64'(r_of64), 64'(of));
  endtask

  logic [33:0] q[$];
  logic [33:0] exp_r, hold_val;
  logic        held;
  int          sent, got, cyc;

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst.out_valid32", 64'(ov32), 64'd0);
    check("rst.out_valid16", 64'(ov16), 64'd0);
    check("rst.out_valid64", 64'(ov64), 64'd0);
    check("rst.sum32", 64'(sum32), 64'd0);
    check("rst.cout32", 64'(co32), 64'd0);
    check("rst.ovf32", 64'(of32), 64'd0);
    check("rst.sum16", 64'(sum16), 64'd0);
    check("rst.sum64", sum64, 64'd0);
    rst = 1'b0;
    #1;
    check("rst.in_ready32", 64'(ir32), 64'd1);
    check("rst.in_ready16", 64'(ir16), 64'd1);
    check("rst.in_ready64", 64'(ir64), 64'd1);

    // Default-config directed vectors
    apply(32'hFFFF_FFFF, 32'h0000_0001, '0, '0, '0, '0, 1'b0, 1'b0);
    chk32("wrap", 32'h0000_0000, 1'b1, 1'b0);
    apply(32'hAAAA_AAAA, 32'h5555_5555, '0, '0, '0, '0, 1'b1, 1'b0);
    chk32("skip_cin1", 32'h0000_0000, 1'b1, 1'b0);
    apply(32'h0F0F_0F0F, 32'hF0F0_F0F0, '0, '0, '0, '0, 1'b0, 1'b0);
    chk32("skip_cin0", 32'hFFFF_FFFF, 1'b0, 1'b0);
    apply(32'd5, 32'd7, '0, '0, '0, '0, 1'b0, 1'b1);
    chk32("sub_neg", 32'hFFFF_FFFE, 1'b0, 1'b0);
    apply(32'h8000_0000, 32'd1, '0, '0, '0, '0, 1'b0, 1'b1);
    chk32("sub_ovf", 32'h7FFF_FFFF, 1'b1, 1'b1);
    apply(32'h7FFF_FFFF, 32'd1, '0, '0, '0, '0, 1'b0, 1'b0);
    chk32("add_ovf", 32'h8000_0000, 1'b0, 1'b1);
    apply(32'd10, 32'd3, '0, '0, '0, '0, 1'b1, 1'b1);
    chk32("sub_cin_ignored", 32'h0000_0007, 1'b1, 1'b0);
    apply(32'h1234_5678, 32'h1234_5678, '0, '0, '0, '0, 1'b0, 1'b1);
    chk32("sub_equal", 32'h0000_0000, 1'b1, 1'b0);

    // Parameter sweep: same vector into all three configurations
    apply(32'd5, 32'd7, 16'h8000, 16'h0001, 64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1);
    chk32("sw1", 32'hFFFF_FFFE, 1'b0, 1'b0);
    chk16("sw1", 16'h7FFF, 1'b1, 1'b1);
    chk64("sw1", 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
    apply(32'd0, 32'd0, 16'hAAAA, 16'h5555, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_0000_0000, 1'b1, 1'b0);
    chk32("sw2", 32'h0000_0001, 1'b0, 1'b0);
    chk16("sw2", 16'h0000, 1'b1, 1'b0);
    chk64("sw2", 64'h0000_0000_0000_0000, 1'b1, 1'b0);
    apply(32'h1234_5678, 32'h1111_1111, 16'h7FFF, 16'h0001, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
    chk32("sw3", 32'h2345_6789, 1'b0, 1'b0);
    chk16("sw3", 16'h8000, 1'b0, 1'b1);
    chk64("sw3", 64'h0000_0000_0000_0000, 1'b1, 1'b0);

    // Backpressure: 8 random pairs, random out_ready, in-order scoreboard
    sent = 0; got = 0; cyc = 0; held = 1'b0; hold_val = '0;
    while (got < 8 && cyc < 300) begin
      out_ready = 1'($urandom_range(0, 1));
      if (sent < 8) begin
        in_valid = 1'b1;
        a32 = $urandom;
        b32 = $urandom;
        Cin = 1'($urandom_range(0, 1));
        Sub = 1'($urandom_range(0, 1));
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (held) begin
        check("bp.hold_valid", 64'(ov32), 64'd1);
        check("bp.hold_data", 64'({of32, co32, sum32}), 64'(hold_val));
      end
      check("bp.in_ready", 64'(ir32), 64'(!(ov32 && !out_ready)));
      if (ov32 && out_ready) begin
        check("bp.result_expected", 64'(q.size() > 0), 64'd1);
        if (q.size() > 0) begin
          exp_r = q.pop_front();
          check("bp.result", 64'({of32, co32, sum32}), 64'(exp_r));
        end
        got++;
      end
      held = ov32 && !out_ready;
      hold_val = {of32, co32, sum32};
      if (in_valid && ir32) begin
        q.push_back(model(a32, b32, Cin, Sub));
        sent++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    check("bp.count", 64'(got), 64'd8);
    check("bp.queue_empty", 64'(q.size()), 64'd0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;

    // Reset with two pairs in flight
    a32 = 32'd1; b32 = 32'd2; a16 = 16'd1; b16 = 16'd2; a64 = 64'd1; b64 = 64'd2;
    Cin = 1'b0; Sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    a32 = 32'd3; b32 = 32'd4;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst.out_valid32", 64'(ov32), 64'd0);
    check("midrst.out_valid16", 64'(ov16), 64'd0);
    check("midrst.out_valid64", 64'(ov64), 64'd0);
    check("midrst.ovf32", 64'(of32), 64'd0);
    rst = 1'b0;
    #1;
    check("midrst.in_ready32", 64'(ir32), 64'd1);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      check("midrst.no_stale32", 64'(ov32), 64'd0);
      check("midrst.no_stale16", 64'(ov16), 64'd0);
    end
    apply(32'h0000_FFFF, 32'h0000_0001, '0, '0, '0, '0, 1'b0, 1'b0);
    chk32("after_rst", 32'h0001_0000, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, %0d tests run", n_tests);
    $fatal(1, "timeout");
  end

endmodule
